// File: rtl/shift194_ctrl.sv
// Sequencer for a downstream 74x194: one parallel load followed by LEN shift cycles.
// Optional feature: define SHIFT194_ROTATE_EN to recirculate QD/QA back into the serial input.
module shift194_ctrl (
   input  logic       CP,
   input  logic       CR,
   input  logic       START,
   input  logic [3:0] DIN,
   input  logic       DIR,
   input  logic [2:0] LEN,
   input  logic       FILL,
   input  logic       ROT,
   input  logic       QA_IN,
   input  logic       QD_IN,
   output logic       S0,
   output logic       S1,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic       DSR,
   output logic       DSL,
   output logic       CLR_N_O,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_din;
   logic       r_dir;
   logic [2:0] r_len;
   logic       r_fill;
   logic       r_rot;
   logic [2:0] r_cnt;
   logic       w_dsr_sh;
   logic       w_dsl_sh;

   always_ff @(posedge CP) begin
      if (CR) begin
         r_state <= IDLE;
         r_din   <= 4'd0;
         r_dir   <= 1'b0;
         r_len   <= 3'd0;
         r_fill  <= 1'b0;
         r_rot   <= 1'b0;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE && START) begin
            r_din  <= DIN;
            r_dir  <= DIR;
            r_len  <= LEN;
            r_fill <= FILL;
            r_rot  <= ROT;
            r_cnt  <= LEN;
         end else if (r_state == SHIFT) begin
            r_cnt  <= r_cnt - 3'd1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (START) w_state_next = LOAD;
         LOAD:    w_state_next = (r_len != 3'd0) ? SHIFT : FIN;
         SHIFT:   if (r_cnt == 3'd1) w_state_next = FIN;
         FIN:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

`ifdef SHIFT194_ROTATE_EN
   // Rotation feeds the bit leaving the far end back into the entering end.
   assign w_dsr_sh = (r_rot && !r_dir) ? QD_IN : r_fill;
   assign w_dsl_sh = (r_rot &&  r_dir) ? QA_IN : r_fill;
`else
   assign w_dsr_sh = r_fill;
   assign w_dsl_sh = r_fill;
   logic w_unused;
   assign w_unused = ^{ROT, QA_IN, QD_IN, r_rot};
`endif

   always_comb begin
      {S1, S0}     = 2'b00;
      {A, B, C, D} = 4'b0000;
      DSR          = 1'b0;
      DSL          = 1'b0;
      BUSY         = 1'b0;
      DONE         = 1'b0;
      case (r_state)
         LOAD: begin
            {S1, S0}     = 2'b11;
            {A, B, C, D} = r_din;
            BUSY         = 1'b1;
         end
         SHIFT: begin
            {S1, S0} = r_dir ? 2'b10 : 2'b01;
            DSR      = w_dsr_sh;
            DSL      = w_dsl_sh;
            BUSY     = 1'b1;
         end
         FIN:     DONE = 1'b1;
         default: ;
      endcase
   end

   assign CLR_N_O = ~CR;

endmodule

// File: doc/shift194_ctrl.md
SHIFT194_CTRL -- requirements
Module: shift194_ctrl

Interface
REQ-001 SHALL have CP, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL have CR, input, 1: synchronous active-high reset, sampled on rising CP.
REQ-003 SHALL have START, input, 1: request to begin one load-and-shift sequence.
REQ-004 SHALL have DIN, input, 4: parallel word to load; DIN[3] maps to A, DIN[0] to D.
REQ-005 SHALL have DIR, input, 1: 0 = shift right (QA toward QD), 1 = shift left.
REQ-006 SHALL have LEN, input, 3: number of shift cycles, 0..7.
REQ-007 SHALL have FILL, input, 1: serial fill bit for the vacated end.
REQ-008 SHALL have ROT, QA_IN, QD_IN, inputs, 1 each: rotate request and feedback from the downstream 194; used only per REQ-026.
REQ-009 SHALL have S0, S1, outputs, 1 each: mode select to the downstream 194.
REQ-010 SHALL have A, B, C, D, outputs, 1 each: parallel data to the downstream 194.
REQ-011 SHALL have DSR, DSL, outputs, 1 each: serial inputs to the downstream 194.
REQ-012 SHALL have CLR_N_O, output, 1: active-low clear to the downstream 194.
REQ-013 SHALL have BUSY and DONE, outputs, 1 each: sequence status.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, LOAD, SHIFT and FIN; outputs decode from registered state only, so the downstream 194 acts on the CP edge that leaves each state.
REQ-015 SHALL, in IDLE with START=1 at an edge, capture DIN, DIR, LEN, FILL and ROT into holding registers and enter LOAD.
REQ-016 SHALL ignore START in LOAD, SHIFT and FIN; holding registers stay unchanged.
REQ-017 SHALL, in LOAD, drive {S1,S0}=11 and {A,B,C,D}=captured DIN for exactly one cycle.
REQ-018 SHALL, leaving LOAD, enter SHIFT when captured LEN>0, else enter FIN directly.
REQ-019 SHALL, in SHIFT, drive {S1,S0}=01 if DIR=0 or 10 if DIR=1, for exactly LEN cycles counted by a 3-bit down-counter preloaded with LEN, then enter FIN.
REQ-020 SHALL drive DSR=DSL=captured FILL in SHIFT when rotation is inactive.
REQ-021 SHALL, in FIN, drive {S1,S0}=00 and DONE=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL drive {S1,S0}=00 in IDLE; A-D=0 and DSR=DSL=0 outside LOAD and SHIFT respectively.
REQ-023 SHALL drive BUSY=1 in LOAD and SHIFT only; a START at the FIN edge is ignored, a START in the IDLE cycle after FIN is accepted.

Reset
REQ-024 SHALL, on CR=1 at an edge, enter IDLE, clear the counter and holding registers, giving S0=S1=0, A-D=0, DSR=DSL=0, BUSY=0, DONE=0; reset mid-sequence aborts with no FIN/DONE.
REQ-025 SHALL drive CLR_N_O=0 while CR=1 (combinational) and CLR_N_O=1 otherwise.

Configuration
REQ-026 SHALL, with macro SHIFT194_ROTATE_EN defined, use captured ROT=1 to drive DSR=QD_IN (DIR=0) or DSL=QA_IN (DIR=1) in SHIFT, the other serial output following FILL.
REQ-027 SHALL, without SHIFT194_ROTATE_EN, ignore ROT, QA_IN and QD_IN and always apply REQ-020; ports remain present.

Verification
REQ-028 Reset: CR=1 for 2 cycles mid-SHIFT -> next cycle S1S0=00, BUSY=0, DONE=0, CLR_N_O=0 during reset, no DONE pulse afterwards.
REQ-029 Right shift: START with DIN=1011, DIR=0, LEN=2, FILL=0 with 194 model -> LOAD 1 cycle (S1S0=11), SHIFT 2 cycles (01), DONE 1 cycle; 194 holds 0010.
REQ-030 Left shift: DIN=0110, DIR=1, LEN=3, FILL=1 -> S1S0=10 for 3 cycles; 194 holds 0111; BUSY high exactly 4 cycles.
REQ-031 Zero length: DIN=1001, LEN=0 -> LOAD then FIN directly, no 01/10 cycle; 194 holds 1001.
REQ-032 Busy START: START re-asserted in every cycle of a LEN=7 sequence -> single sequence, holding registers unchanged; START in the IDLE cycle after FIN starts a second sequence.
REQ-033 Rotate (macro defined): DIN=1000, DIR=0, ROT=1, LEN=4 -> 194 returns to 1000; without macro same stimulus -> 194 holds 0000 with FILL=0.
